// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: time-shares a 4-digit hex display between N_SRC value sources with dwell rotation, manual advance/hold and a blinking one-shot alert
// Ports: clk, rst_n (async, active-low); src_val/src_valid (packed per-source values and valid levels);
// btn_next (advance pulse), hold (freeze dwell), alert_req/alert_val (alert request and value);
// alert_ack (accept pulse), disp_val/disp_blank (registered display value and per-digit blank),
// cur_src (source shown), in_alert (alert on display).
module seg_display_scheduler #(
    parameter int N_SRC        = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int ALERT_CYCLES = 200_000_000,
    parameter int BLINK_CYCLES = 25_000_000,
    parameter int LZ_BLANK     = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [16*N_SRC-1:0]                         src_val,
    input  logic [N_SRC-1:0]                            src_valid,
    input  logic                                        btn_next,
    input  logic                                        hold,
    input  logic                                        alert_req,
    input  logic [15:0]                                 alert_val,
    output logic                                        alert_ack,
    output logic [15:0]                                 disp_val,
    output logic [3:0]                                  disp_blank,
    output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] cur_src,
    output logic                                        in_alert
);
    localparam int CW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int AW = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cur_src_q, cur_src_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [AW-1:0]   alert_cnt_q, alert_cnt_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;
    logic [15:0]     alert_val_q, alert_val_d;
    logic [15:0]     disp_val_q, disp_val_d;
    logic [3:0]      disp_blank_q, disp_blank_d;
    logic            alert_ack_q, alert_ack_d;
    logic            in_alert_q, in_alert_d;
    logic [CW-1:0]   nxt_idx, low_idx, idx;
    logic            any_valid, accept;
    logic [15:0]     shown;
    logic [3:0]      lead_zero;

    // Round-robin search: scanning offsets downward lets the smallest offset win.
    // With no other valid source the result stays at cur_src.
    always_comb begin
        nxt_idx = cur_src_q;
        low_idx = '0;
        idx     = '0;
        for (int k = N_SRC - 1; k >= 1; k--) begin
            idx = CW'((int'(cur_src_q) + k) % N_SRC);
            if (src_valid[idx]) nxt_idx = idx;
        end
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) low_idx = CW'(i);
        end
        any_valid = |src_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_src_q    <= '0;
            dwell_q      <= '0;
            alert_cnt_q  <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            alert_val_q  <= '0;
            disp_val_q   <= '0;
            disp_blank_q <= 4'hF;
            alert_ack_q  <= 1'b0;
            in_alert_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_src_q    <= cur_src_d;
            dwell_q      <= dwell_d;
            alert_cnt_q  <= alert_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            alert_val_q  <= alert_val_d;
            disp_val_q   <= disp_val_d;
            disp_blank_q <= disp_blank_d;
            alert_ack_q  <= alert_ack_d;
            in_alert_q   <= in_alert_d;
        end
    end

    // Alert acceptance outranks everything else in IDLE/SHOW, so a same-cycle
    // btn_next or dwell expiry is simply dropped.
    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        dwell_d     = dwell_q;
        alert_cnt_d = alert_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        alert_val_d = alert_val_q;
        accept      = 1'b0;
        if (state_q != ALERT && alert_req) begin
            accept      = 1'b1;
            state_d     = ALERT;
            alert_val_d = alert_val;
            alert_cnt_d = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (state_q == IDLE) begin
            if (any_valid) begin
                state_d   = SHOW;
                cur_src_d = low_idx;
                dwell_d   = '0;
            end
        end else if (state_q == SHOW) begin
            if (!any_valid) begin
                state_d = IDLE;
                dwell_d = '0;
            end else if (!src_valid[cur_src_q] || btn_next || (!hold && dwell_q == DWELL_LAST)) begin
                cur_src_d = nxt_idx;
                dwell_d   = '0;
            end else if (!hold) begin
                dwell_d = dwell_q + 1'b1;
            end
        end else begin
            alert_cnt_d = alert_cnt_q + 1'b1;
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
            blink_on_d  = (blink_cnt_q == BLINK_LAST) ? !blink_on_q : blink_on_q;
            if (btn_next || alert_cnt_q == ALERT_LAST) begin
                state_d     = any_valid ? SHOW : IDLE;
                cur_src_d   = src_valid[cur_src_q] ? cur_src_q : nxt_idx;
                dwell_d     = '0;
                alert_cnt_d = '0;
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end
        end
    end

    // Outputs are computed from the state being entered, so the registered
    // display always matches the registered cur_src/in_alert.
    always_comb begin
        shown        = src_val[16*cur_src_d +: 16];
        lead_zero    = {~|shown[15:12], ~|shown[15:8], ~|shown[15:4], 1'b0};
        alert_ack_d  = accept;
        in_alert_d   = state_d == ALERT;
        disp_val_d   = (state_d == ALERT) ? alert_val_d : (state_d == SHOW) ? shown : 16'h0;
        disp_blank_d = (state_d == ALERT) ? {4{!blink_on_d}} :
                       (state_d == SHOW)  ? ((LZ_BLANK != 0) ? lead_zero : 4'h0) : 4'hF;
    end

    assign alert_ack  = alert_ack_q;
    assign disp_val   = disp_val_q;
    assign disp_blank = disp_blank_q;
    assign cur_src    = cur_src_q;
    assign in_alert   = in_alert_q;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: directed scenarios plus randomized traffic checked against a behavioural model
module tb_seg_display_scheduler;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int AC = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] src_val = '0;
    logic [3:0]  src_valid = '0;
    logic        btn_next = 1'b0;
    logic        hold = 1'b0;
    logic        alert_req = 1'b0;
    logic [15:0] alert_val = '0;
    logic        alert_ack;
    logic [15:0] disp_val;
    logic [3:0]  disp_blank;
    logic [1:0]  cur_src;
    logic        in_alert;

    int n_tests = 0;
    int n_fail = 0;

    // model state: 0 idle, 1 show, 2 alert
    int          m_state, m_cur, m_dwell, m_acnt;
    logic [15:0] m_aval;
    logic        e_ack;
    logic [15:0] e_val;
    logic [3:0]  e_blank;

    always #5 clk = ~clk;

    seg_display_scheduler #(
        .N_SRC(N), .DWELL_CYCLES(DW), .ALERT_CYCLES(AC), .BLINK_CYCLES(BC), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_val(src_val), .src_valid(src_valid),
        .btn_next(btn_next), .hold(hold), .alert_req(alert_req), .alert_val(alert_val),
        .alert_ack(alert_ack), .disp_val(disp_val), .disp_blank(disp_blank),
        .cur_src(cur_src), .in_alert(in_alert)
    );

    function automatic logic [3:0] lz(input logic [15:0] v);
        lz = 4'h0;
        for (int k = 1; k < 4; k++) if ((v >> (4 * k)) == 16'h0) lz[k] = 1'b1;
    endfunction

    function automatic int nxt(input int cur);
        for (int k = 1; k <= N; k++) if (src_valid[2'((cur + k) % N)]) return (cur + k) % N;
        return cur;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cur = 0; m_dwell = 0; m_acnt = 0; m_aval = '0;
        e_ack = 1'b0; e_val = '0; e_blank = 4'hF;
    endtask

    task automatic model_step();
        e_ack = 1'b0;
        if (m_state != 2 && alert_req) begin
            m_state = 2; m_aval = alert_val; m_acnt = 0; e_ack = 1'b1;
        end else if (m_state == 0) begin
            if (src_valid != 0) begin m_state = 1; m_cur = nxt(N - 1); m_dwell = 0; end
        end else if (m_state == 1) begin
            if (src_valid == 0) begin m_state = 0; m_dwell = 0; end
            else if (!src_valid[2'(m_cur)] || btn_next || (!hold && m_dwell == DW - 1)) begin
                m_cur = nxt(m_cur); m_dwell = 0;
            end else if (!hold) m_dwell++;
        end else begin
            m_acnt++;
            if (btn_next || m_acnt == AC) begin
                m_dwell = 0;
                if (src_valid == 0) m_state = 0;
                else begin
                    m_state = 1;
                    if (!src_valid[2'(m_cur)]) m_cur = nxt(m_cur);
                end
            end
        end
        e_val   = (m_state == 2) ? m_aval : (m_state == 1) ? src_val[16*m_cur +: 16] : 16'h0;
        e_blank = (m_state == 2) ? (((m_acnt / BC) % 2 != 0) ? 4'hF : 4'h0) :
                  (m_state == 1) ? lz(e_val) : 4'hF;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        n_tests++;
        if ({disp_val, disp_blank, alert_ack, in_alert, cur_src} !== {16'h0, 4'hF, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got val=%h blank=%h ack=%b alert=%b cur=%0d, want 0000 F 0 0 0",
                     disp_val, disp_blank, alert_ack, in_alert, cur_src);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({disp_val, disp_blank, alert_ack} !== {16'h0, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL idle_%0d: got val=%h blank=%h ack=%b, want 0000 F 0", i, disp_val, disp_blank, alert_ack);
            end
        end
    endtask

    task automatic test_rotation();
        int seq[4] = '{0, 1, 3, 0};
        logic [15:0] ev;
        src_val = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        src_valid = 4'b1011;
        for (int i = 0; i < 13; i++) begin
            tick();
            ev = 16'(16'h1111 * (seq[i / 4] == 3 ? 4 : seq[i / 4] + 1));
            n_tests++;
            if ({cur_src, disp_val, disp_blank} !== {2'(seq[i / 4]), ev, 4'h0}) begin
                n_fail++;
                $display("FAIL rotation_%0d: got cur=%0d val=%h blank=%h, want cur=%0d val=%h blank=0",
                         i, cur_src, disp_val, disp_blank, seq[i / 4], ev);
            end
        end
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (cur_src !== 2'd0) begin
                n_fail++;
                $display("FAIL hold_%0d: got cur=%0d, want 0", i, cur_src);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_manual();
        for (int i = 0; i < 3; i++) tick();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        n_tests++;
        if (cur_src !== 2'd1) begin
            n_fail++;
            $display("FAIL btn_with_expiry: got cur=%0d, want 1", cur_src);
        end
        tick();
        n_tests++;
        if (cur_src !== 2'd1) begin
            n_fail++;
            $display("FAIL dwell_restart: got cur=%0d, want 1", cur_src);
        end
        src_valid = 4'b1001;
        tick();
        n_tests++;
        if ({cur_src, disp_val} !== {2'd3, 16'h4444}) begin
            n_fail++;
            $display("FAIL dropout: got cur=%0d val=%h, want 3 4444", cur_src, disp_val);
        end
        src_valid = 4'b0000;
        tick();
        n_tests++;
        if ({disp_val, disp_blank} !== {16'h0, 4'hF}) begin
            n_fail++;
            $display("FAIL to_idle: got val=%h blank=%h, want 0000 F", disp_val, disp_blank);
        end
    endtask

    task automatic test_alert();
        logic [3:0] pat[8] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
        src_valid = 4'b1011;
        tick();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        n_tests++;
        if (cur_src !== 2'd1) begin
            n_fail++;
            $display("FAIL alert_setup: got cur=%0d, want 1", cur_src);
        end
        alert_req = 1'b1; alert_val = 16'hBEEF; btn_next = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            btn_next = 1'b0;
            if (i == 3) alert_req = 1'b0;
            n_tests++;
            if ({alert_ack, in_alert, disp_val, disp_blank, cur_src} !== {i == 0, 1'b1, 16'hBEEF, pat[i], 2'd1}) begin
                n_fail++;
                $display("FAIL alert_%0d: got ack=%b alert=%b val=%h blank=%h cur=%0d, want ack=%b 1 BEEF %h 1",
                         i, alert_ack, in_alert, disp_val, disp_blank, cur_src, i == 0, pat[i]);
            end
        end
        tick();
        n_tests++;
        if ({alert_ack, in_alert, cur_src, disp_val} !== {1'b0, 1'b0, 2'd1, 16'h2222}) begin
            n_fail++;
            $display("FAIL alert_exit: got ack=%b alert=%b cur=%0d val=%h, want 0 0 1 2222",
                     alert_ack, in_alert, cur_src, disp_val);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (cur_src !== (i < 3 ? 2'd1 : 2'd3)) begin
                n_fail++;
                $display("FAIL post_alert_dwell_%0d: got cur=%0d, want %0d", i, cur_src, i < 3 ? 1 : 3);
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals[3] = '{16'h0040, 16'h0000, 16'h1000};
        logic [3:0]  blk[3]  = '{4'b1100, 4'b1110, 4'b0000};
        src_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            src_val[15:0] = vals[i];
            tick();
            n_tests++;
            if ({cur_src, disp_val, disp_blank} !== {2'd0, vals[i], blk[i]}) begin
                n_fail++;
                $display("FAIL lz_%0d: got cur=%0d val=%h blank=%b, want 0 %h %b",
                         i, cur_src, disp_val, disp_blank, vals[i], blk[i]);
            end
        end
    endtask

    task automatic test_reset_mid_alert();
        src_valid = 4'b1011;
        alert_req = 1'b1; alert_val = 16'h1234;
        tick();
        alert_req = 1'b0;
        n_tests++;
        if ({alert_ack, in_alert, disp_val} !== {1'b1, 1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL mid_alert_accept: got ack=%b alert=%b val=%h, want 1 1 1234", alert_ack, in_alert, disp_val);
        end
        tick();
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        src_valid = 4'b1010;
        #1;
        n_tests++;
        if ({disp_val, disp_blank, alert_ack, in_alert, cur_src} !== {16'h0, 4'hF, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got val=%h blank=%h ack=%b alert=%b cur=%0d, want 0000 F 0 0 0",
                     disp_val, disp_blank, alert_ack, in_alert, cur_src);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_tests++;
        if ({in_alert, cur_src, disp_val} !== {1'b0, 2'd1, 16'h2222}) begin
            n_fail++;
            $display("FAIL restart: got alert=%b cur=%0d val=%h, want 0 1 2222", in_alert, cur_src, disp_val);
        end
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (cur_src !== 2'd3) begin
            n_fail++;
            $display("FAIL restart_rotation: got cur=%0d, want 3", cur_src);
        end
    endtask

    task automatic test_random();
        #2 rst_n = 1'b0;
        model_reset();
        btn_next = 1'b0; hold = 1'b0; alert_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 7) == 0) src_valid = 4'($urandom_range(0, 15));
            for (int s = 0; s < N; s++) src_val[16*s +: 16] = 16'($urandom) >> $urandom_range(0, 16);
            btn_next  = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 5) == 0) hold = ~hold;
            alert_req = $urandom_range(0, 14) == 0;
            alert_val = 16'($urandom) >> $urandom_range(0, 16);
            tick();
            n_tests++;
            if ({alert_ack, in_alert, cur_src, disp_val, disp_blank} !== {e_ack, m_state == 2, 2'(m_cur), e_val, e_blank}) begin
                n_fail++;
                $display("FAIL random_%0d: got ack=%b alert=%b cur=%0d val=%h blank=%h, want ack=%b alert=%b cur=%0d val=%h blank=%h",
                         c, alert_ack, in_alert, cur_src, disp_val, disp_blank, e_ack, m_state == 2, m_cur, e_val, e_blank);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_manual();
        test_alert();
        test_lz();
        test_reset_mid_alert();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
